// File: rtl/arp_pkg.sv
// ARP transmitter shared definitions: protocol constants, FSM states, send modes
// and the packed 42-byte ARP-over-Ethernet header image.
// Ports: none (package).
package arp_pkg;

  localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;
  localparam logic [15:0] HTYPE_ETH    = 16'h0001;
  localparam logic [15:0] PTYPE_IPV4   = 16'h0800;
  localparam logic [7:0]  HLEN         = 8'd6;
  localparam logic [7:0]  PLEN         = 8'd4;
  localparam logic [15:0] OP_REQUEST   = 16'd1;
  localparam logic [15:0] OP_REPLY     = 16'd2;

  // Bytes of real header content; everything after this is zero padding.
  localparam int HDR_BYTES = 42;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GRANT,
    WAIT_DATA,
    SEND,
    WAIT_END
  } state_t;

  typedef enum logic [1:0] {
    REQ,
    REP,
    GRAT
  } mode_t;

  // Field order matches wire order, so the packed image MSB byte is byte 0.
  typedef struct packed {
    logic [47:0] eth_dst;
    logic [47:0] eth_src;
    logic [15:0] eth_type;
    logic [15:0] htype;
    logic [15:0] ptype;
    logic [7:0]  hlen;
    logic [7:0]  plen;
    logic [15:0] oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [47:0] tha;
    logic [31:0] tpa;
  } arp_hdr_t;

endpackage

// File: rtl/arp_byte_sel.sv
// Purpose: picks one frame byte out of the header image by byte index (padding -> 0).
// Latency: combinational.
// Backpressure: none; pure lookup.
// Ports: idx (frame byte index), hdr (latched header image), byte_o (selected byte).
module arp_byte_sel
  import arp_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic [IDX_W-1:0] idx,
  input  arp_hdr_t         hdr,
  output logic [7:0]       byte_o
);

  logic [HDR_BYTES*8-1:0] hdr_bits;

  assign hdr_bits = hdr;

  always_comb begin
    byte_o = 8'h00;
    if (idx < IDX_W'(HDR_BYTES)) begin
      byte_o = hdr_bits[(HDR_BYTES - 1 - int'(idx)) * 8 +: 8];
    end
  end

endmodule

// File: rtl/arp_tx_mw.sv
// Purpose: builds request/reply/gratuitous ARP frames and streams them to the MAC,
//          re-arbitrating on data-request timeout up to MAX_RETRY times.
// Latency: all outputs registered, one cycle behind the FSM state; beat 0 two cycles after mac_data_req.
// Backpressure: none once SEND starts; flow control is the grant / data-request handshake only.
// Ports: address inputs, level request inputs (reply > request > gratuitous), arbitration
//        handshake (arp_tx_req / mac_tx_ack / mac_data_req / mac_send_end), byte-lane stream
//        (arp_tx_valid/data/keep/end), arp_tx_ready, arp_reply_ack and arp_tx_fail pulses.
module arp_tx_mw
  import arp_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 60,
  parameter int TIMEOUT   = 65535,
  parameter int MAX_RETRY = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [47:0]         source_mac_addr,
  input  logic [31:0]         source_ip_addr,
  input  logic [47:0]         destination_mac_addr,
  input  logic [31:0]         destination_ip_addr,
  input  logic [47:0]         arp_rec_source_mac_addr,
  input  logic [31:0]         arp_rec_source_ip_addr,
  input  logic                arp_request_req,
  input  logic                arp_reply_req,
  input  logic                arp_grat_req,
  output logic                arp_reply_ack,
  output logic                arp_tx_req,
  input  logic                mac_tx_ack,
  input  logic                mac_data_req,
  input  logic                mac_send_end,
  output logic                arp_tx_ready,
  output logic                arp_tx_valid,
  output logic [DATA_W-1:0]   arp_tx_data,
  output logic [DATA_W/8-1:0] arp_tx_keep,
  output logic                arp_tx_end,
  output logic                arp_tx_fail
);

  localparam int LANES     = DATA_W / 8;
  localparam int BYTE_W    = $clog2(FRAME_LEN + 4);
  localparam int TIMEOUT_W = $clog2(TIMEOUT + 1);
  // +2 keeps the counter at least one bit wide when MAX_RETRY is 0.
  localparam int RETRY_W   = $clog2(MAX_RETRY + 2);

  state_t               state;
  logic [BYTE_W-1:0]    byte_idx;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic [RETRY_W-1:0]   retry_cnt;
  logic                 send_end_q;

  // Fields frozen when a frame is launched so the whole frame is self-consistent.
  logic [47:0] eth_dst_q;
  logic [15:0] oper_q;
  logic [47:0] sha_q;
  logic [31:0] spa_q;
  logic [47:0] tha_q;
  logic [31:0] tpa_q;

  arp_hdr_t          hdr;
  logic [DATA_W-1:0] beat_dat;
  logic [LANES-1:0]  beat_keep;
  logic              last_beat;
  logic              req_any;
  mode_t             req_mode;

  assign hdr = '{
    eth_dst:  eth_dst_q,
    eth_src:  sha_q,
    eth_type: ETH_TYPE_ARP,
    htype:    HTYPE_ETH,
    ptype:    PTYPE_IPV4,
    hlen:     HLEN,
    plen:     PLEN,
    oper:     oper_q,
    sha:      sha_q,
    spa:      spa_q,
    tha:      tha_q,
    tpa:      tpa_q
  };

  always_comb begin
    req_any  = arp_reply_req | arp_request_req | arp_grat_req;
    req_mode = GRAT;
    if (arp_reply_req) begin
      req_mode = REP;
    end else if (arp_request_req) begin
      req_mode = REQ;
    end
  end

  // byte_idx is the index of lane 0 (MSB lane); the beat is last once it covers FRAME_LEN-1.
  assign last_beat = (byte_idx >= BYTE_W'(FRAME_LEN - LANES));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [BYTE_W-1:0] idx;
    logic [7:0]        lane_byte;

    assign idx = byte_idx + BYTE_W'(l);

    arp_byte_sel #(
      .IDX_W (BYTE_W)
    ) u_byte_sel (
      .idx    (idx),
      .hdr    (hdr),
      .byte_o (lane_byte)
    );

    // Lanes past the end of the frame are masked off and driven to zero.
    assign beat_keep[LANES-1-l]         = (idx < BYTE_W'(FRAME_LEN));
    assign beat_dat[DATA_W-1-8*l -: 8]  = beat_keep[LANES-1-l] ? lane_byte : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      byte_idx      <= '0;
      tmo_cnt       <= '0;
      retry_cnt     <= '0;
      send_end_q    <= 1'b0;
      eth_dst_q     <= '0;
      oper_q        <= '0;
      sha_q         <= '0;
      spa_q         <= '0;
      tha_q         <= '0;
      tpa_q         <= '0;
      arp_reply_ack <= 1'b0;
      arp_tx_req    <= 1'b0;
      arp_tx_ready  <= 1'b0;
      arp_tx_valid  <= 1'b0;
      arp_tx_data   <= '0;
      arp_tx_keep   <= '0;
      arp_tx_end    <= 1'b0;
      arp_tx_fail   <= 1'b0;
    end else begin
      send_end_q    <= mac_send_end;
      arp_reply_ack <= 1'b0;
      arp_tx_fail   <= 1'b0;

      // Outputs mirror the state of the current cycle, hence the one-cycle lag.
      arp_tx_req   <= (state == WAIT_GRANT);
      arp_tx_ready <= (state == WAIT_DATA);
      arp_tx_valid <= (state == SEND);
      arp_tx_end   <= (state == SEND) && last_beat;
      arp_tx_data  <= (state == SEND) ? beat_dat  : '0;
      arp_tx_keep  <= (state == SEND) ? beat_keep : '0;

      case (state)
        IDLE: begin
          if (req_any) begin
            state     <= WAIT_GRANT;
            retry_cnt <= '0;
            sha_q     <= source_mac_addr;
            spa_q     <= source_ip_addr;
            case (req_mode)
              REP: begin
                eth_dst_q     <= arp_rec_source_mac_addr;
                oper_q        <= OP_REPLY;
                tha_q         <= arp_rec_source_mac_addr;
                tpa_q         <= arp_rec_source_ip_addr;
                arp_reply_ack <= 1'b1;
              end
              REQ: begin
                eth_dst_q <= destination_mac_addr;
                oper_q    <= OP_REQUEST;
                tha_q     <= destination_mac_addr;
                tpa_q     <= destination_ip_addr;
              end
              default: begin
                eth_dst_q <= 48'hFFFF_FFFF_FFFF;
                oper_q    <= OP_REQUEST;
                tha_q     <= '0;
                tpa_q     <= source_ip_addr;
              end
            endcase
          end
        end

        WAIT_GRANT: begin
          if (mac_tx_ack) begin
            state   <= WAIT_DATA;
            tmo_cnt <= '0;
          end
        end

        WAIT_DATA: begin
          // A data request on the timeout cycle still wins.
          if (mac_data_req) begin
            state    <= SEND;
            byte_idx <= '0;
          end else if (tmo_cnt == TIMEOUT_W'(TIMEOUT - 1)) begin
            if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
              retry_cnt <= retry_cnt + RETRY_W'(1);
              state     <= WAIT_GRANT;
            end else begin
              arp_tx_fail <= 1'b1;
              retry_cnt   <= '0;
              state       <= IDLE;
            end
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
          end
        end

        SEND: begin
          byte_idx <= byte_idx + BYTE_W'(LANES);
          if (last_beat) begin
            state <= WAIT_END;
          end
        end

        WAIT_END: begin
          if (send_end_q) begin
            state     <= IDLE;
            retry_cnt <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arp_tx_mw.sv
// Bench for arp_tx_mw: an 8-bit/60-byte instance and a 32-bit/62-byte instance share
// the address inputs; a select steers handshake stimulus and observation to one of them.
// Expected frames come from a byte-offset model of the ARP frame layout.
module tb_arp_tx_mw;

  localparam int M_REQ  = 0;
  localparam int M_REP  = 1;
  localparam int M_GRAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [47:0] src_mac, dst_mac, rec_mac;
  logic [31:0] src_ip, dst_ip, rec_ip;
  logic        c_req, c_rep, c_grat, c_ack, c_dreq, c_end;
  int          sel;
  logic        sel_a;

  logic       a_ack, a_txreq, a_ready, a_valid, a_end, a_fail;
  logic [7:0] a_data;
  logic [0:0] a_keep;
  logic        b_ack, b_txreq, b_ready, b_valid, b_end, b_fail;
  logic [31:0] b_data;
  logic [3:0]  b_keep;

  logic        o_ack, o_txreq, o_ready, o_valid, o_end, o_fail;
  logic [31:0] o_data;
  logic [3:0]  o_keep;

  assign sel_a   = (sel == 0);
  assign o_ack   = sel_a ? a_ack   : b_ack;
  assign o_txreq = sel_a ? a_txreq : b_txreq;
  assign o_ready = sel_a ? a_ready : b_ready;
  assign o_valid = sel_a ? a_valid : b_valid;
  assign o_end   = sel_a ? a_end   : b_end;
  assign o_fail  = sel_a ? a_fail  : b_fail;
  assign o_data  = sel_a ? {24'h0, a_data} : b_data;
  assign o_keep  = sel_a ? {3'b0, a_keep}  : b_keep;

  arp_tx_mw #(.DATA_W(8), .FRAME_LEN(60), .TIMEOUT(16), .MAX_RETRY(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .source_mac_addr(src_mac), .source_ip_addr(src_ip),
    .destination_mac_addr(dst_mac), .destination_ip_addr(dst_ip),
    .arp_rec_source_mac_addr(rec_mac), .arp_rec_source_ip_addr(rec_ip),
    .arp_request_req(c_req & sel_a), .arp_reply_req(c_rep & sel_a), .arp_grat_req(c_grat & sel_a),
    .arp_reply_ack(a_ack), .arp_tx_req(a_txreq),
    .mac_tx_ack(c_ack & sel_a), .mac_data_req(c_dreq & sel_a), .mac_send_end(c_end & sel_a),
    .arp_tx_ready(a_ready), .arp_tx_valid(a_valid), .arp_tx_data(a_data),
    .arp_tx_keep(a_keep), .arp_tx_end(a_end), .arp_tx_fail(a_fail)
  );

  arp_tx_mw #(.DATA_W(32), .FRAME_LEN(62), .TIMEOUT(16), .MAX_RETRY(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .source_mac_addr(src_mac), .source_ip_addr(src_ip),
    .destination_mac_addr(dst_mac), .destination_ip_addr(dst_ip),
    .arp_rec_source_mac_addr(rec_mac), .arp_rec_source_ip_addr(rec_ip),
    .arp_request_req(c_req & ~sel_a), .arp_reply_req(c_rep & ~sel_a), .arp_grat_req(c_grat & ~sel_a),
    .arp_reply_ack(b_ack), .arp_tx_req(b_txreq),
    .mac_tx_ack(c_ack & ~sel_a), .mac_data_req(c_dreq & ~sel_a), .mac_send_end(c_end & ~sel_a),
    .arp_tx_ready(b_ready), .arp_tx_valid(b_valid), .arp_tx_data(b_data),
    .arp_tx_keep(b_keep), .arp_tx_end(b_end), .arp_tx_fail(b_fail)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reply-ack pulses, counted on the falling edge.
  int ack_cnt = 0;
  always @(negedge clk) if (o_ack) ack_cnt++;

  logic [7:0] exp_b [0:1513];

  task automatic put(input int off, input logic [63:0] v, input int n);
    for (int j = 0; j < n; j++) exp_b[off+j] = 8'(v >> (8 * (n - 1 - j)));
  endtask

  task automatic build_frame(input int mode);
    logic [47:0] ed, tm;
    logic [31:0] tp;
    logic [15:0] op;
    for (int i = 0; i < 1514; i++) exp_b[i] = 8'h00;
    case (mode)
      M_REP:   begin ed = rec_mac; op = 16'd2; tm = rec_mac; tp = rec_ip; end
      M_REQ:   begin ed = dst_mac; op = 16'd1; tm = dst_mac; tp = dst_ip; end
      default: begin ed = 48'hFFFF_FFFF_FFFF; op = 16'd1; tm = 48'h0; tp = src_ip; end
    endcase
    put(0, ed, 6);
    put(6, src_mac, 6);
    put(12, 64'h0806, 2);
    put(14, 64'h0001, 2);
    put(16, 64'h0800, 2);
    put(18, 64'h06, 1);
    put(19, 64'h04, 1);
    put(20, op, 2);
    put(22, src_mac, 6);
    put(28, src_ip, 4);
    put(32, tm, 6);
    put(38, tp, 4);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_addrs();
    src_mac = {16'($urandom), $urandom};
    dst_mac = {16'($urandom), $urandom};
    rec_mac = {16'($urandom), $urandom};
    src_ip  = $urandom;
    dst_ip  = $urandom;
    rec_ip  = $urandom;
  endtask

  // Acts as the MAC for one frame of the selected instance and checks every beat.
  // drop: request bits (0 request, 1 reply, 2 grat) released once arbitration starts.
  task automatic serve(input int mode, input int lanes, input int flen, input int drop, input int rst_beat);
    int n, nbeats, idx;
    logic [31:0] ed;
    logic [3:0]  ek;
    build_frame(mode);
    nbeats = (flen + lanes - 1) / lanes;
    n = 0;
    while (!o_txreq && n < 30) begin tick(); n++; end
    check("txreq_seen", o_txreq, 1);
    if (!o_txreq) return;
    if (drop[0]) c_req  = 1'b0;
    if (drop[1]) c_rep  = 1'b0;
    if (drop[2]) c_grat = 1'b0;
    repeat ($urandom_range(0, 4)) tick();
    c_ack = 1'b1;
    tick();
    c_ack = 1'b0;
    n = 0;
    while (!o_ready && n < 30) begin tick(); n++; end
    check("ready_seen", o_ready, 1);
    if (!o_ready) return;
    repeat ($urandom_range(0, 8)) tick();
    c_dreq = 1'b1;
    tick();
    c_dreq = 1'b0;
    check("valid_early", o_valid, 0);
    tick();
    for (int k = 0; k < nbeats; k++) begin
      ed = '0;
      ek = '0;
      for (int l = 0; l < lanes; l++) begin
        idx = k * lanes + l;
        if (idx < flen) begin
          ed[(lanes-1-l)*8 +: 8] = exp_b[idx];
          ek[lanes-1-l] = 1'b1;
        end
      end
      check($sformatf("valid[%0d]", k), o_valid, 1);
      check($sformatf("data[%0d]", k), o_data, ed);
      check($sformatf("keep[%0d]", k), o_keep, ek);
      check($sformatf("end[%0d]", k), o_end, (k == nbeats - 1));
      if (k == rst_beat) begin
        rst_n = 1'b0;
        #1;
        check("rst_mid_outs", {o_ack, o_txreq, o_ready, o_valid, o_end, o_fail, o_keep, o_data}, 0);
        check("rst_mid_valid", o_valid, 0);
        return;
      end
      tick();
    end
    check("valid_after", o_valid, 0);
    repeat ($urandom_range(0, 3)) tick();
    c_end = 1'b1;
    tick();
    c_end = 1'b0;
    tick();
    tick();
  endtask

  task automatic start_mode(input int mode);
    case (mode)
      M_REQ:   c_req  = 1'b1;
      M_REP:   c_rep  = 1'b1;
      default: c_grat = 1'b1;
    endcase
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int ack_base, m, rdy, rise, fails, rdy_fail;
    logic prev;
    rst_n = 1'b0;
    sel = 0;
    c_req = 0; c_rep = 0; c_grat = 0; c_ack = 0; c_dreq = 0; c_end = 0;
    randomize_addrs();
    repeat (3) tick();
    check("rst_a", {a_ack, a_txreq, a_ready, a_valid, a_end, a_fail, a_keep, a_data}, 0);
    check("rst_b", {b_ack, b_txreq, b_ready, b_valid, b_end, b_fail, b_keep, b_data}, 0);
    #3 rst_n = 1'b1;
    tick();

    // Plain request on the 8-bit instance; no reply ack expected.
    ack_base = ack_cnt;
    c_req = 1'b1;
    serve(M_REQ, 1, 60, 1, -1);
    check("req_no_ack", ack_cnt - ack_base, 0);

    // Random modes and addresses, alternating instances.
    for (int i = 0; i < 8; i++) begin
      sel = i % 2;
      randomize_addrs();
      m = $urandom_range(0, 2);
      start_mode(m);
      serve(m, sel ? 4 : 1, sel ? 62 : 60, 1 << m, -1);
    end

    // Reply beats a simultaneous request; the request follows automatically.
    sel = 0;
    randomize_addrs();
    ack_base = ack_cnt;
    c_rep = 1'b1;
    c_req = 1'b1;
    serve(M_REP, 1, 60, 2, -1);
    check("rep_ack_once", ack_cnt - ack_base, 1);
    serve(M_REQ, 1, 60, 1, -1);
    check("rep_ack_total", ack_cnt - ack_base, 1);

    // Gratuitous ARP with a fixed source IP on both widths.
    for (int s = 0; s < 2; s++) begin
      sel = s;
      randomize_addrs();
      src_ip = 32'hC0A8_0002;
      c_grat = 1'b1;
      serve(M_GRAT, s ? 4 : 1, s ? 62 : 60, 4, -1);
    end

    // Timeout with retries: data request never arrives.
    sel = 0;
    c_req = 1'b1;
    rdy = 0; rise = 0; fails = 0; rdy_fail = -1; prev = 1'b0;
    for (int t = 0; t < 200; t++) begin
      tick();
      c_ack = o_txreq;
      if (o_txreq) c_req = 1'b0;
      if (o_ready && fails == 0) rdy++;
      if (o_txreq && !prev) rise++;
      prev = o_txreq;
      if (o_fail) begin
        fails++;
        if (fails == 1) rdy_fail = rdy;
      end
    end
    c_ack = 1'b0;
    check("tmo_fail_cnt", fails, 1);
    check("tmo_grant_entries", rise, 3);
    check("tmo_wait_cycles", rdy_fail, 48);
    check("tmo_idle_req", o_txreq, 0);
    check("tmo_idle_ready", o_ready, 0);

    // Reset in the middle of a frame, then a clean frame.
    sel = 0;
    randomize_addrs();
    c_req = 1'b1;
    serve(M_REQ, 1, 60, 1, 20);
    #3 rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_idle", o_txreq, 0);
    randomize_addrs();
    c_req = 1'b1;
    serve(M_REQ, 1, 60, 1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
